mod_enc_key_expansion: RTL and testbench
========================================

Name: mod_enc_key_expansion

Overview:
- AES-256 key schedule stage (FIPS-197) that sits directly upstream of the encryption AddRoundKey stage.
- Accepts a 256-bit cipher key and streams the 15 round keys (rounds 0..14) in order over a valid/ready handshake, one per cycle when the consumer is ready.
- Each round key is a 16-byte array in the same byte layout the AddRoundKey `k` input consumes.
- Expansion is iterative: one round key (4 words) is computed per accepted transfer from an 8-word sliding window, so no 60-word storage is needed.

Parameters:
- CLEAR_ON_DONE, 1, when 1 the key window register is zeroed on the cycle the final round key is accepted (key hygiene); when 0 it retains its last value.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- key  input  [7:0] x16 x2 (unpacked byte array, 32 entries, index 0 = first key byte)  cipher key
- key_valid  input  1  key present
- key_ready  output  1  block can accept a key (high only in IDLE)
- rk  output  [7:0] x16 (unpacked, index 0 = first byte)  current round key; maps 1:1 to AddRoundKey `k[i]`
- rk_idx  output  4  round number of rk, 0..14
- rk_valid  output  1  rk/rk_idx valid
- rk_ready  input  1  consumer accepts rk
- done  output  1  one-cycle pulse after round key 14 accepted

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst); polarity and synchronicity are fixed.
- Word convention: word j = bytes {4j, 4j+1, 4j+2, 4j+3}, with byte 4j most significant.
  - Round key r = words w[4r..4r+3].
  - rk[b] = byte b of that 16-byte group.
- State machine: IDLE, RUN.
- Reset (rst=1 at edge), any state:
  - state <= IDLE; window <= 0; rnd <= 0; done <= 0.
  - Outputs then read rk_valid=0, rk=all zero, rk_idx=0, key_ready=1.
  - A reset mid-RUN aborts the stream immediately; no done pulse.
- IDLE:
  - key_ready=1, rk_valid=0.
  - On key_valid=1: window <= key (w0..w7), rnd <= 0, go RUN.
  - Latency from key accept to first rk_valid is 1 cycle.
- RUN, outputs:
  - key_ready=0; key_valid is ignored.
  - rk_valid=1; rk = window words 0..3; rk_idx = rnd.
  - rk and rk_idx hold stable while rk_valid=1 and rk_ready=0.
- RUN, transfer (rk_valid & rk_ready):
  - If rnd==14: go IDLE, done <= 1 for exactly one cycle, rk_valid drops the next cycle. If CLEAR_ON_DONE=1, window <= 0.
  - Else: rnd <= rnd+1; window <= {window w4..w7, n0..n3}.
- Next-word computation, with i = 4*(rnd+2):
  - t = window w7.
  - If rnd even: t = SubWord(RotWord(t)) ^ {Rcon[(rnd+2)/2], 00, 00, 00}.
  - If rnd odd: t = SubWord(t).
  - n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2.
  - All computed combinationally in one cycle.
- Rcon[1..7] = 01, 02, 04, 08, 10, 20, 40.
  - Index 8 (reached only while computing unused words after round 13) is 80; its result is never output.
- S-box: 4 combinational FIPS-197 forward S-box byte lookups.
- Throughput: with rk_ready held high, 15 round keys in 15 consecutive cycles, then 1 IDLE cycle before the next key can be accepted.
  - done and key_ready are both high in that IDLE cycle; a key_valid in that cycle is accepted.
- rk_ready while rk_valid=0 has no effect.
- The key input is sampled only on the accept cycle; later changes are ignored.

Test Plan:
- FIPS-197 C.3 key 00 01 .. 1f, rk_ready=1 (the consumer accepts every cycle):
  - rk_idx 0 = 00..0f.
  - rk_idx 1 = 10..1f.
  - rk_idx 2 = a573c29f a176c498 a97fce93 a572c09c.
  - rk_idx 14 = 24fc79cc bf0979e9 371ac23c 6d68de36.
  - Keys arrive on 15 consecutive cycles; done pulses once.
- Appendix A.3 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> rk_idx 2 = 9ba35411 8e6925af a51a8b5f 2067fcde; all 15 keys match the golden model.
- Random rk_ready backpressure -> rk/rk_idx stable while stalled, no key skipped or duplicated, same 15-key sequence as the unstalled run.
- key_valid pulsed during RUN -> ignored (key_ready=0), stream continues on the original key; a key presented on the done cycle -> accepted, new rk_idx 0 = its first 16 bytes next cycle.
- rst asserted while rk_idx=6 is pending -> next cycle rk_valid=0, rk=0, key_ready=1, no done; a fresh key restarts at rk_idx 0.
- CLEAR_ON_DONE=1 vs 0 after the final transfer -> internal window = 0 vs retained; rk_valid=0 in both cases.

Source files
------------

// File: rtl/mod_enc_key_expansion_if.sv
// mod_enc_key_expansion_if: key-in / round-key-out handshake bundle for the AES-256 key schedule.
interface mod_enc_key_expansion_if;
    logic [7:0] key [32];
    logic       key_valid;
    logic       key_ready;
    logic [7:0] rk [16];
    logic [3:0] rk_idx;
    logic       rk_valid;
    logic       rk_ready;
    logic       done;
    modport master (output key, key_valid, rk_ready, input key_ready, rk, rk_idx, rk_valid, done);
    modport slave (input key, key_valid, rk_ready, output key_ready, rk, rk_idx, rk_valid, done);
endinterface

// File: rtl/mod_enc_key_expansion.sv
// mod_enc_key_expansion: iterative AES-256 key schedule streaming round keys 0..14 from an 8-word window.
module mod_enc_key_expansion #(
    parameter bit CLEAR_ON_DONE = 1'b1
) (
    input logic                     clk,
    input logic                     rst,
    mod_enc_key_expansion_if.slave  kx
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction
    logic [0:0]  state_q, state_d;
    logic [31:0] window_q [8];
    logic [31:0] window_d [8];
    logic [3:0]  rnd_q, rnd_d;
    logic        done_q, done_d;
    logic [7:0]  rcon;
    logic [31:0] t, n0, n1, n2, n3;
    // even rounds start a new 8-word block (rotate + rcon), odd rounds are the mid-block SubWord step
    assign rcon = 8'h01 << rnd_q[3:1];
    assign t  = rnd_q[0] ? sub_word(window_q[7])
                         : sub_word({window_q[7][23:0], window_q[7][31:24]}) ^ {rcon, 24'h0};
    assign n0 = window_q[0] ^ t;
    assign n1 = window_q[1] ^ n0;
    assign n2 = window_q[2] ^ n1;
    assign n3 = window_q[3] ^ n2;
    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        rnd_d    = rnd_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (kx.key_valid) begin
                state_d = RUN;
                rnd_d   = '0;
                for (int j = 0; j < 8; j++)
                    window_d[j] = {kx.key[4*j], kx.key[4*j+1], kx.key[4*j+2], kx.key[4*j+3]};
            end
        end else if (kx.rk_ready) begin
            if (rnd_q == 4'd14) begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (CLEAR_ON_DONE) window_d = '{default: '0};
            end else begin
                rnd_d = rnd_q + 4'd1;
                for (int j = 0; j < 4; j++) window_d[j] = window_q[j+4];
                window_d[4] = n0;
                window_d[5] = n1;
                window_d[6] = n2;
                window_d[7] = n3;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            window_q <= '{default: '0};
            rnd_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            rnd_q    <= rnd_d;
            done_q   <= done_d;
        end
    end
    always_comb begin
        for (int b = 0; b < 16; b++) kx.rk[b] = window_q[b/4][31-8*(b%4) -: 8];
    end
    assign kx.key_ready = state_q == IDLE;
    assign kx.rk_valid  = state_q == RUN;
    assign kx.rk_idx    = rnd_q;
    assign kx.done      = done_q;
endmodule

// File: tb/tb_mod_enc_key_expansion.sv
// tb_mod_enc_key_expansion: random-stimulus bench against a textbook FIPS-197 expansion model.
module tb_mod_enc_key_expansion;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    mod_enc_key_expansion_if k0 ();
    mod_enc_key_expansion_if k1 ();
    mod_enc_key_expansion #(.CLEAR_ON_DONE(1'b1)) dut0 (.clk(clk), .rst(rst), .kx(k0.slave));
    mod_enc_key_expansion #(.CLEAR_ON_DONE(1'b0)) dut1 (.clk(clk), .rst(rst), .kx(k1.slave));
    always_comb begin
        k1.key       = k0.key;
        k1.key_valid = k0.key_valid;
        k1.rk_ready  = k0.rk_ready;
    end
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0]   sb [256];
    logic [7:0]   key_v [32];
    logic [31:0]  w [64];
    logic [127:0] cap [15];
    logic [127:0] ref_cap [15];
    logic [255:0] kv;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction
    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction
    task automatic init_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask
    function automatic logic [31:0] sw(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction
    task automatic model();
        for (int i = 0; i < 8; i++) w[i] = {key_v[4*i], key_v[4*i+1], key_v[4*i+2], key_v[4*i+3]};
        for (int i = 8; i < 64; i++) begin
            logic [31:0] tmp = w[i-1];
            if (i % 8 == 0) tmp = sw({tmp[23:0], tmp[31:24]}) ^ {8'(1 << (i/8 - 1)), 24'h0};
            else if (i % 8 == 4) tmp = sw(tmp);
            w[i] = w[i-8] ^ tmp;
        end
    endtask
    function automatic logic [127:0] rk_of(input int r);
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction
    function automatic logic [127:0] dut_rk();
        logic [127:0] v;
        for (int b = 0; b < 16; b++) v[127-8*b -: 8] = k0.rk[b];
        return v;
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic start_key();
        int t = 0;
        while (!k0.key_ready && t < 50) begin
            step();
            t++;
        end
        chk("key_ready_before_load", k0.key_ready, 1);
        k0.key = key_v;
        k0.key_valid = 1'b1;
        model();
        step();
        k0.key_valid = 1'b0;
    endtask
    task automatic stream(input int stall, input bit intrude);
        int exp_idx = 0;
        int cyc = 0;
        bit fin = 0;
        while (!fin && cyc < 300) begin
            chk("done_low_in_run", k0.done, 0);
            chk("rk_valid", k0.rk_valid, 1);
            chk("key_ready_in_run", k0.key_ready, 0);
            chk("rk_idx", k0.rk_idx, 128'(exp_idx));
            chk("rk", dut_rk(), rk_of(exp_idx));
            if (intrude && cyc == 4) begin
                for (int b = 0; b < 32; b++) k0.key[b] = 8'($urandom);
                k0.key_valid = 1'b1;
            end else k0.key_valid = 1'b0;
            k0.rk_ready = ($urandom_range(99) >= 32'(stall));
            if (k0.rk_ready) begin
                cap[exp_idx] = dut_rk();
                fin = (exp_idx == 14);
                exp_idx++;
            end
            step();
            cyc++;
        end
        k0.key_valid = 1'b0;
        k0.rk_ready = 1'b0;
        chk("stream_finished", fin, 1);
        chk("done_pulse", k0.done, 1);
        chk("rk_valid_after_last", k0.rk_valid, 0);
        chk("key_ready_on_done", k0.key_ready, 1);
        if (stall == 0) chk("stream_cycles", 128'(cyc), 15);
    endtask
    initial begin
        rst = 1'b1;
        k0.key_valid = 1'b0;
        k0.rk_ready = 1'b0;
        k0.key = '{default: '0};
        init_sbox();
        step();
        step();
        chk("reset_rk_valid", k0.rk_valid, 0);
        chk("reset_rk", dut_rk(), 0);
        chk("reset_rk_idx", k0.rk_idx, 0);
        chk("reset_key_ready", k0.key_ready, 1);
        chk("reset_done", k0.done, 0);
        rst = 1'b0;
        step();
        // FIPS-197 C.3 key, consumer always ready
        for (int i = 0; i < 32; i++) key_v[i] = 8'(i);
        start_key();
        stream(0, 0);
        chk("c3_rk0", cap[0], 128'h000102030405060708090a0b0c0d0e0f);
        chk("c3_rk1", cap[1], 128'h101112131415161718191a1b1c1d1e1f);
        chk("c3_rk2", cap[2], 128'ha573c29fa176c498a97fce93a572c09c);
        chk("c3_rk14", cap[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        for (int j = 0; j < 8; j++) begin
            chk("window_cleared", dut0.window_q[j], 0);
            chk("window_retained", dut1.window_q[j], w[56+j]);
        end
        chk("nonclear_rk_valid", k1.rk_valid, 0);
        step();
        chk("done_single_pulse", k0.done, 0);
        // A.3 key with a key_valid intrusion mid-run, then reloaded on the done cycle under backpressure
        kv = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        for (int i = 0; i < 32; i++) key_v[i] = kv[255-8*i -: 8];
        start_key();
        stream(0, 1);
        chk("a3_rk2", cap[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        ref_cap = cap;
        start_key();
        stream(50, 0);
        for (int r = 0; r < 15; r++) chk("stalled_matches_unstalled", cap[r], ref_cap[r]);
        step();
        chk("done_single_pulse2", k0.done, 0);
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 32; i++) key_v[i] = 8'($urandom);
            start_key();
            stream(int'($urandom_range(70)), n[0]);
            step();
        end
        // reset while round key 6 is pending
        for (int i = 0; i < 32; i++) key_v[i] = 8'($urandom);
        start_key();
        k0.rk_ready = 1'b1;
        for (int t = 0; t < 30 && k0.rk_idx != 4'd6; t++) step();
        chk("reached_idx6", k0.rk_idx, 6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        k0.rk_ready = 1'b0;
        chk("abort_rk_valid", k0.rk_valid, 0);
        chk("abort_rk", dut_rk(), 0);
        chk("abort_key_ready", k0.key_ready, 1);
        chk("abort_done", k0.done, 0);
        step();
        chk("abort_no_done", k0.done, 0);
        for (int i = 0; i < 32; i++) key_v[i] = 8'($urandom);
        start_key();
        stream(20, 0);
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
